tmds_word_scheduler: RTL and testbench

TMDS_WORD_SCHEDULER -- requirements
Module: tmds_word_scheduler

---
 rtl/tmds_word_scheduler.sv | 146 ++++++++++++++
 tb/tb_tmds_word_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tmds_word_scheduler.sv
// TMDS word scheduler: picks control, training, pixel (and optionally guard) words and
// holds each for five x_clk cycles. Define TMDS_GUARD_BAND_EN to insert a two-word guard band.
module tmds_word_scheduler #(
    parameter int         MIN_CTRL_WORDS = 12,
    parameter logic [9:0] TRAIN_WORD     = 10'b1111100000
) (
    input  logic       x_clk,
    input  logic       rst,
    input  logic [9:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [1:0] ctl_sel,
    input  logic       train_en,
    output logic [9:0] word_out,
    output logic       word_load,
    output logic       video_active
);

    localparam int              CNT_W      = $clog2(MIN_CTRL_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MIN_CTRL_WORDS);
    localparam logic [9:0]      RESET_WORD = 10'b1101010100;

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [9:0] GUARD_WORD = 10'b1011001100;
    typedef enum logic [1:0] {CTRL, GUARD, VIDEO, TRAIN} state_t;
`else
    typedef enum logic [1:0] {CTRL, VIDEO, TRAIN} state_t;
`endif

    function automatic logic [9:0] ctl_token(input logic [1:0] sel);
        logic [9:0] tok;
        case (sel)
            2'b00:   tok = 10'b1101010100;
            2'b01:   tok = 10'b0010101011;
            2'b10:   tok = 10'b0101010100;
            default: tok = 10'b1010101011;
        endcase
        return tok;
    endfunction

    state_t           state, next_state;
    logic [2:0]       ph;
    logic [CNT_W-1:0] ctl_cnt, next_cnt;
    logic [9:0]       next_word;
    logic             next_video;
    logic             boundary;
`ifdef TMDS_GUARD_BAND_EN
    logic             guard_cnt, next_guard_cnt;
`endif

    assign boundary  = (ph == 3'd4);
    assign pix_ready = boundary && (next_state == VIDEO) && !rst;

    // Next-word selection, only committed when ph==4
    always_comb begin
        next_state = state;
        next_word  = word_out;
        next_video = 1'b0;
        next_cnt   = ctl_cnt;
`ifdef TMDS_GUARD_BAND_EN
        next_guard_cnt = guard_cnt;
`endif
        if (train_en) begin
            next_state = TRAIN;
            next_word  = TRAIN_WORD;
        end else begin
            case (state)
                CTRL: begin
                    if (pix_valid && (ctl_cnt >= CNT_MAX)) begin
`ifdef TMDS_GUARD_BAND_EN
                        next_state     = GUARD;
                        next_word      = GUARD_WORD;
                        next_guard_cnt = 1'b0;
`else
                        next_state = VIDEO;
                        next_word  = pix_data;
                        next_video = 1'b1;
`endif
                    end else begin
                        next_word = ctl_token(ctl_sel);
                        next_cnt  = (ctl_cnt >= CNT_MAX) ? CNT_MAX : ctl_cnt + 1'b1;
                    end
                end
`ifdef TMDS_GUARD_BAND_EN
                GUARD: begin
                    if (!guard_cnt) begin
                        next_word      = GUARD_WORD;
                        next_guard_cnt = 1'b1;
                    end else if (pix_valid) begin
                        next_state = VIDEO;
                        next_word  = pix_data;
                        next_video = 1'b1;
                    end else begin
                        next_state = CTRL;
                        next_word  = ctl_token(ctl_sel);
                        next_cnt   = '0;
                    end
                end
`endif
                VIDEO: begin
                    if (pix_valid) begin
                        next_word  = pix_data;
                        next_video = 1'b1;
                    end else begin
                        next_state = CTRL;
                        next_word  = ctl_token(ctl_sel);
                        next_cnt   = '0;
                    end
                end
                default: begin
                    next_state = CTRL;
                    next_word  = ctl_token(ctl_sel);
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Phase counter and word registers
    always_ff @(posedge x_clk) begin
        if (rst) begin
            ph           <= 3'd0;
            state        <= CTRL;
            ctl_cnt      <= '0;
            word_out     <= RESET_WORD;
            word_load    <= 1'b0;
            video_active <= 1'b0;
`ifdef TMDS_GUARD_BAND_EN
            guard_cnt    <= 1'b0;
`endif
        end else begin
            ph        <= boundary ? 3'd0 : ph + 3'd1;
            word_load <= boundary;
            if (boundary) begin
                state        <= next_state;
                word_out     <= next_word;
                video_active <= next_video;
                ctl_cnt      <= next_cnt;
`ifdef TMDS_GUARD_BAND_EN
                guard_cnt    <= next_guard_cnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tmds_word_scheduler.sv
// Scoreboard bench for tmds_word_scheduler: a word-level reference model predicts each
// loaded word; a negedge monitor checks outputs every cycle.
module tb_tmds_word_scheduler;

    localparam int MIN_CW = 12;
    localparam logic [9:0] TRAIN_W = 10'b1111100000;
    localparam logic [9:0] GUARD_W = 10'b1011001100;
    localparam int K_CTRL = 0, K_GUARD = 1, K_PIX = 2, K_TRAIN = 3;

    logic       x_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pix_data = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [1:0] ctl_sel = 2'b00;
    logic       train_en = 1'b0;
    logic [9:0] word_out;
    logic       word_load;
    logic       video_active;

    tmds_word_scheduler #(.MIN_CTRL_WORDS(MIN_CW), .TRAIN_WORD(TRAIN_W)) dut (
        .x_clk(x_clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .ctl_sel(ctl_sel), .train_en(train_en),
        .word_out(word_out), .word_load(word_load), .video_active(video_active)
    );

    always #5 x_clk = ~x_clk;

    typedef struct packed { logic [9:0] w; logic v; } exp_t;
    exp_t sb[$];

    logic [9:0] tok [4];
    int n_checks = 0, n_fail = 0;
    int mph = 0, last_kind = K_CTRL, run = 0, guards = 0;
    int epoch = 0, model_xfers = 0, dut_xfers = 0;
    bit checking = 0, exp_load = 0, exp_ready = 0;

    initial begin
        tok[0] = 10'b1101010100; tok[1] = 10'b0010101011;
        tok[2] = 10'b0101010100; tok[3] = 10'b1010101011;
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Word-level model: what goes on the wire after this boundary
    task automatic model_step();
        int kind;
        logic [9:0] w;
        kind = K_CTRL;
        w = tok[ctl_sel];
        if (train_en) begin
            kind = K_TRAIN; w = TRAIN_W;
        end else if (last_kind == K_PIX || last_kind == K_TRAIN) begin
            if (last_kind == K_PIX && pix_valid) begin kind = K_PIX; w = pix_data; end
            else run = 0;
        end else if (last_kind == K_GUARD) begin
            if (guards < 2) begin kind = K_GUARD; w = GUARD_W; guards++; end
            else if (pix_valid) begin kind = K_PIX; w = pix_data; end
            else run = 0;
        end else begin
            if (pix_valid && run >= MIN_CW) begin
`ifdef TMDS_GUARD_BAND_EN
                kind = K_GUARD; w = GUARD_W; guards = 1;
`else
                kind = K_PIX; w = pix_data;
`endif
            end else run++;
        end
        if (kind == K_PIX) model_xfers++;
        last_kind = kind;
        sb.push_back('{w: w, v: (kind == K_PIX)});
        exp_ready = (kind == K_PIX);
    endtask

    // mode: 0 idle, 1 stream, 2 random, 3 stream with training held
    task automatic tick(input int mode, input bit do_rst);
        @(posedge x_clk); #1;
        if (rst) begin
            mph = 0; last_kind = K_CTRL; run = 0; guards = 0;
            sb.delete(); epoch++; exp_load = 0; checking = 1;
        end else begin
            exp_load = (mph == 4);
            mph = (mph == 4) ? 0 : mph + 1;
        end
        rst = do_rst;
        case (mode)
            0: begin pix_valid = 0; ctl_sel = 2'b00; train_en = 0; end
            1: begin pix_valid = 1; pix_data = 10'h2AA; ctl_sel = 2'($urandom); train_en = 0; end
            2: begin
                pix_valid = ($urandom_range(0, 9) != 0);
                pix_data  = 10'($urandom);
                ctl_sel   = 2'($urandom);
                if ($urandom_range(0, 59) == 0) train_en = ~train_en;
            end
            default: begin pix_valid = 1; pix_data = 10'($urandom); train_en = 1; end
        endcase
        exp_ready = 0;
        if (!rst && mph == 4) model_step();
    endtask

    // Run stream mode until the next tick lands at ph==2 of a pixel word
    task automatic wait_video_ph1();
        bit found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick(1, 0);
            if (last_kind == K_PIX && mph == 1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_video: no video word within budget");
        end
    endtask

    int seen_epoch = 0;
    exp_t cur;
    always @(negedge x_clk) begin
        if (checking) begin
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                cur = '{w: 10'b1101010100, v: 1'b0};
            end
            if (word_load === 1'b1) begin
                if (sb.size() == 0) check("load_without_expected", 10'd1, 10'd0);
                else cur = sb.pop_front();
            end
            check("word_load", {9'd0, word_load}, {9'd0, exp_load});
            check("word_out", word_out, cur.w);
            check("video_active", {9'd0, video_active}, {9'd0, cur.v});
            check("pix_ready", {9'd0, pix_ready}, {9'd0, exp_ready});
            if (pix_valid && pix_ready) dut_xfers++;
        end
    end

    initial begin
        tick(0, 1);
        tick(0, 1);
        for (int i = 0; i < 60; i++) tick(0, 0);
        for (int i = 0; i < 400; i++) tick(1, 0);
        wait_video_ph1();
        tick(3, 0);
        for (int i = 0; i < 14; i++) tick(3, 0);
        for (int i = 0; i < 120; i++) tick(1, 0);
        wait_video_ph1();
        tick(1, 1);
        for (int i = 0; i < 120; i++) tick(1, 0);
        for (int i = 0; i < 5000; i++) tick(2, (i % 1777) == 1000);
        for (int i = 0; i < 200; i++) tick(1, 0);
        @(posedge x_clk); #1;
        checking = 0;
        check("transfer_count", 10'(dut_xfers), 10'(model_xfers));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
